// File: rtl/apb_timer8.sv
// apb_timer8: 8-bit up-counting timer (auto-reload, compare match, one IRQ) behind a zero-wait APB3 slave.
// Define TMR_PRESCALER_EN to add the PRESC register at 0x05 and the tick divider.
module apb_timer8 #(
    parameter logic [7:0] LOAD_RST = 8'h00,
    parameter logic [7:0] CMP_RST  = 8'hFF
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       PSEL,
    input  logic       PENABLE,
    input  logic       PWRITE,
    input  logic [7:0] PADDR,
    input  logic [7:0] PWDATA,
    output logic [7:0] PRDATA,
    output logic       PREADY,
    output logic       PSLVERR,
    output logic       IRQ
);
    localparam logic [7:0] A_CTRL   = 8'h00;
    localparam logic [7:0] A_LOAD   = 8'h01;
    localparam logic [7:0] A_CMP    = 8'h02;
    localparam logic [7:0] A_COUNT  = 8'h03;
    localparam logic [7:0] A_STATUS = 8'h04;
`ifdef TMR_PRESCALER_EN
    localparam logic [7:0] A_PRESC  = 8'h05;
`endif

    logic       access, addr_ok, wr_en, rd_en;
    logic       wr_ctrl, wr_load, wr_cmp, wr_count, wr_status;
    logic       tick;
    logic [3:0] ctrl_q, ctrl_d;
    logic [7:0] load_q, load_d, cmp_q, cmp_d, count_q, count_d;
    logic       ovf_q, ovf_d, cmpf_q, cmpf_d;
    logic       ovf_set, cmpf_set;

    assign access = PSEL & PENABLE;

    always_comb begin
        case (PADDR)
            A_CTRL, A_LOAD, A_CMP, A_COUNT, A_STATUS: addr_ok = 1'b1;
`ifdef TMR_PRESCALER_EN
            A_PRESC: addr_ok = 1'b1;
`endif
            default: addr_ok = 1'b0;
        endcase
    end

    assign wr_en     = access & PWRITE & addr_ok;
    assign rd_en     = access & ~PWRITE & addr_ok;
    assign wr_ctrl   = wr_en & (PADDR == A_CTRL);
    assign wr_load   = wr_en & (PADDR == A_LOAD);
    assign wr_cmp    = wr_en & (PADDR == A_CMP);
    assign wr_count  = wr_en & (PADDR == A_COUNT);
    assign wr_status = wr_en & (PADDR == A_STATUS);

`ifdef TMR_PRESCALER_EN
    logic [7:0] presc_q, presc_d, div_q, div_d;
    logic       wr_presc;

    assign wr_presc = wr_en & (PADDR == A_PRESC);
    assign tick     = ctrl_q[0] & (div_q == presc_q);

    // Divider restarts whenever software turns the timer on, so the first tick is a full period away.
    always_comb begin
        presc_d = wr_presc ? PWDATA : presc_q;
        div_d   = div_q;
        if (wr_ctrl & PWDATA[0] & ~ctrl_q[0])
            div_d = 8'h00;
        else if (ctrl_q[0])
            div_d = tick ? 8'h00 : div_q + 8'd1;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            presc_q <= 8'h00;
            div_q   <= 8'h00;
        end else begin
            presc_q <= presc_d;
            div_q   <= div_d;
        end
    end
`else
    assign tick = ctrl_q[0];
`endif

    always_comb begin
        ctrl_d   = wr_ctrl ? PWDATA[3:0] : ctrl_q;
        load_d   = wr_load ? PWDATA : load_q;
        cmp_d    = wr_cmp  ? PWDATA : cmp_q;
        count_d  = count_q;
        ovf_set  = 1'b0;
        cmpf_set = 1'b0;
        // A software COUNT write overrides the tick entirely, including its flags.
        if (wr_count) begin
            count_d = PWDATA;
        end else if (tick) begin
            if (count_q == 8'hFF) begin
                count_d = load_q;
                ovf_set = 1'b1;
                if (ctrl_q[3] && !wr_ctrl)
                    ctrl_d[0] = 1'b0;
            end else begin
                count_d = count_q + 8'd1;
            end
            cmpf_set = (count_d == cmp_q);
        end
        ovf_d  = (ovf_q  & ~(wr_status & PWDATA[0])) | ovf_set;
        cmpf_d = (cmpf_q & ~(wr_status & PWDATA[1])) | cmpf_set;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            ctrl_q  <= 4'h0;
            load_q  <= LOAD_RST;
            cmp_q   <= CMP_RST;
            count_q <= 8'h00;
            ovf_q   <= 1'b0;
            cmpf_q  <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            load_q  <= load_d;
            cmp_q   <= cmp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            cmpf_q  <= cmpf_d;
        end
    end

    always_comb begin
        PRDATA = 8'h00;
        if (rd_en) begin
            case (PADDR)
                A_CTRL:   PRDATA = {4'h0, ctrl_q};
                A_LOAD:   PRDATA = load_q;
                A_CMP:    PRDATA = cmp_q;
                A_COUNT:  PRDATA = count_q;
                A_STATUS: PRDATA = {6'h00, cmpf_q, ovf_q};
`ifdef TMR_PRESCALER_EN
                A_PRESC:  PRDATA = presc_q;
`endif
                default:  PRDATA = 8'h00;
            endcase
        end
    end

    assign PREADY  = 1'b1;
    assign PSLVERR = access & ~addr_ok;
    assign IRQ     = ~PRESET & ((ovf_q & ctrl_q[1]) | (cmpf_q & ctrl_q[2]));

endmodule

// File: tb/tb_apb_timer8.sv
// Testbench for apb_timer8: per-feature tasks, expected APB read results queued then checked in order.
module tb_apb_timer8;
    logic       PCLK = 1'b0;
    logic       PRESET = 1'b1;
    logic       PSEL = 1'b0;
    logic       PENABLE = 1'b0;
    logic       PWRITE = 1'b0;
    logic [7:0] PADDR = 8'h00;
    logic [7:0] PWDATA = 8'h00;
    logic [7:0] PRDATA;
    logic       PREADY, PSLVERR, IRQ;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       err;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0] rd_data;
    logic       rd_err, rd_rdy, wr_err;

    apb_timer8 dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .IRQ(IRQ)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at posedge+1; returns at posedge+1 after the commit edge.
    task automatic apb_write(input logic [7:0] a, input logic [7:0] d, output logic err);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #1 err = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        $display("apb wr addr=%02h data=%02h slverr=%0b", a, d, err);
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [7:0] d, output logic err, output logic rdy);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #1 d = PRDATA; err = PSLVERR; rdy = PREADY;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        $display("apb rd addr=%02h data=%02h slverr=%0b ready=%0b", a, d, err, rdy);
    endtask

    task automatic test_reset();
        exp_t e;
        logic [7:0] rst_val [5];
        rst_val = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'h00};
        PRESET = 1'b1;
        repeat (3) @(posedge PCLK);
        #1;
        n_checks++;
        if (PREADY !== 1'b1 || IRQ !== 1'b0 || PRDATA !== 8'h00 || PSLVERR !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got ready=%0b irq=%0b prdata=%02h slverr=%0b want 1 0 00 0",
                     PREADY, IRQ, PRDATA, PSLVERR);
        end
        PRESET = 1'b0;
        for (int a = 0; a < 5; a++) exp_q.push_back('{8'(a), rst_val[a], 1'b0});
        while (exp_q.size() > 0) begin
            apb_read(exp_q[0].addr, rd_data, rd_err, rd_rdy);
            e = exp_q.pop_front();
            n_checks++;
            if (rd_data !== e.data || rd_err !== e.err || rd_rdy !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_read addr=%02h got data=%02h err=%0b rdy=%0b want data=%02h err=%0b rdy=1",
                         e.addr, rd_data, rd_err, rd_rdy, e.data, e.err);
            end
        end
    endtask

    task automatic test_overflow();
        exp_t e;
        apb_write(8'h02, 8'h80, wr_err);
        apb_write(8'h01, 8'hF0, wr_err);
        apb_write(8'h03, 8'hFE, wr_err);
        apb_write(8'h00, 8'h03, wr_err);
        @(posedge PCLK); @(posedge PCLK); #1;
        n_checks++;
        if (IRQ !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_irq_set got irq=%0b want 1", IRQ);
        end
        exp_q.push_back('{8'h03, 8'hF1, 1'b0});
        exp_q.push_back('{8'h04, 8'h01, 1'b0});
        while (exp_q.size() > 0) begin
            apb_read(exp_q[0].addr, rd_data, rd_err, rd_rdy);
            e = exp_q.pop_front();
            n_checks++;
            if (rd_data !== e.data || rd_err !== e.err) begin
                n_fail++;
                $display("FAIL ovf_read addr=%02h got %02h/%0b want %02h/%0b", e.addr, rd_data, rd_err, e.data, e.err);
            end
        end
        apb_write(8'h04, 8'h01, wr_err);
        n_checks++;
        if (IRQ !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_w1c_irq got irq=%0b want 0", IRQ);
        end
        apb_write(8'h00, 8'h00, wr_err);
        exp_q.push_back('{8'h03, 8'hF8, 1'b0});
        exp_q.push_back('{8'h04, 8'h00, 1'b0});
        while (exp_q.size() > 0) begin
            apb_read(exp_q[0].addr, rd_data, rd_err, rd_rdy);
            e = exp_q.pop_front();
            n_checks++;
            if (rd_data !== e.data || rd_err !== e.err) begin
                n_fail++;
                $display("FAIL ovf_frozen addr=%02h got %02h/%0b want %02h/%0b", e.addr, rd_data, rd_err, e.data, e.err);
            end
        end
    endtask

    task automatic test_compare();
        exp_t e;
        apb_write(8'h04, 8'h03, wr_err);
        apb_write(8'h02, 8'h05, wr_err);
        apb_write(8'h03, 8'h00, wr_err);
        apb_write(8'h00, 8'h05, wr_err);
        for (int i = 1; i <= 5; i++) begin
            @(posedge PCLK); #1;
            n_checks++;
            if (IRQ !== (i == 5)) begin
                n_fail++;
                $display("FAIL cmp_irq tick=%0d got irq=%0b want %0b", i, IRQ, (i == 5));
            end
        end
        exp_q.push_back('{8'h04, 8'h02, 1'b0});
        apb_read(exp_q[0].addr, rd_data, rd_err, rd_rdy);
        e = exp_q.pop_front();
        n_checks++;
        if (rd_data !== e.data) begin
            n_fail++;
            $display("FAIL cmp_status got %02h want %02h", rd_data, e.data);
        end
        apb_write(8'h00, 8'h00, wr_err);
        exp_q.push_back('{8'h03, 8'h09, 1'b0});
        exp_q.push_back('{8'h00, 8'h00, 1'b0});
        while (exp_q.size() > 0) begin
            apb_read(exp_q[0].addr, rd_data, rd_err, rd_rdy);
            e = exp_q.pop_front();
            n_checks++;
            if (rd_data !== e.data || rd_err !== e.err) begin
                n_fail++;
                $display("FAIL cmp_read addr=%02h got %02h/%0b want %02h/%0b", e.addr, rd_data, rd_err, e.data, e.err);
            end
        end
    endtask

    task automatic test_oneshot();
        exp_t e;
        apb_write(8'h04, 8'h03, wr_err);
        apb_write(8'h03, 8'hFF, wr_err);
        apb_write(8'h00, 8'h09, wr_err);
        exp_q.push_back('{8'h00, 8'h08, 1'b0});
        exp_q.push_back('{8'h03, 8'hF0, 1'b0});
        exp_q.push_back('{8'h04, 8'h01, 1'b0});
        while (exp_q.size() > 0) begin
            apb_read(exp_q[0].addr, rd_data, rd_err, rd_rdy);
            e = exp_q.pop_front();
            n_checks++;
            if (rd_data !== e.data || rd_err !== e.err) begin
                n_fail++;
                $display("FAIL oneshot_read addr=%02h got %02h/%0b want %02h/%0b", e.addr, rd_data, rd_err, e.data, e.err);
            end
        end
        repeat (6) @(posedge PCLK);
        #1;
        n_checks++;
        if (IRQ !== 1'b0) begin
            n_fail++;
            $display("FAIL oneshot_irq got irq=%0b want 0", IRQ);
        end
        exp_q.push_back('{8'h03, 8'hF0, 1'b0});
        apb_read(exp_q[0].addr, rd_data, rd_err, rd_rdy);
        e = exp_q.pop_front();
        n_checks++;
        if (rd_data !== e.data) begin
            n_fail++;
            $display("FAIL oneshot_hold got count=%02h want %02h", rd_data, e.data);
        end
    endtask

    task automatic test_error();
        exp_t e;
        logic [7:0] bad_addr [3];
        bad_addr = '{8'h06, 8'h83, 8'h40};
        for (int i = 0; i < 3; i++) begin
            apb_write(bad_addr[i], 8'h55, wr_err);
            n_checks++;
            if (wr_err !== 1'b1) begin
                n_fail++;
                $display("FAIL err_write addr=%02h got slverr=%0b want 1", bad_addr[i], wr_err);
            end
            exp_q.push_back('{bad_addr[i], 8'h00, 1'b1});
        end
`ifndef TMR_PRESCALER_EN
        apb_write(8'h05, 8'h55, wr_err);
        n_checks++;
        if (wr_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_write_presc got slverr=%0b want 1", wr_err);
        end
        exp_q.push_back('{8'h05, 8'h00, 1'b1});
`endif
        exp_q.push_back('{8'h00, 8'h08, 1'b0});
        exp_q.push_back('{8'h01, 8'hF0, 1'b0});
        exp_q.push_back('{8'h02, 8'h05, 1'b0});
        exp_q.push_back('{8'h03, 8'hF0, 1'b0});
        exp_q.push_back('{8'h04, 8'h01, 1'b0});
        while (exp_q.size() > 0) begin
            apb_read(exp_q[0].addr, rd_data, rd_err, rd_rdy);
            e = exp_q.pop_front();
            n_checks++;
            if (rd_data !== e.data || rd_err !== e.err) begin
                n_fail++;
                $display("FAIL err_read addr=%02h got %02h/%0b want %02h/%0b", e.addr, rd_data, rd_err, e.data, e.err);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        apb_write(8'h00, 8'h00, wr_err);
        apb_write(8'h04, 8'h03, wr_err);
        apb_write(8'h02, 8'h10, wr_err);
        apb_write(8'h01, 8'h00, wr_err);
        apb_write(8'h03, 8'hFE, wr_err);
        apb_write(8'h00, 8'h01, wr_err);
        // COUNT write lands on the edge that would have wrapped 0xFF.
        apb_write(8'h03, 8'h20, wr_err);
        exp_q.push_back('{8'h04, 8'h00, 1'b0});
        apb_read(exp_q[0].addr, rd_data, rd_err, rd_rdy);
        e = exp_q.pop_front();
        n_checks++;
        if (rd_data !== e.data) begin
            n_fail++;
            $display("FAIL wr_beats_tick_flag got status=%02h want %02h", rd_data, e.data);
        end
        apb_write(8'h00, 8'h00, wr_err);
        exp_q.push_back('{8'h03, 8'h24, 1'b0});
        apb_read(exp_q[0].addr, rd_data, rd_err, rd_rdy);
        e = exp_q.pop_front();
        n_checks++;
        if (rd_data !== e.data) begin
            n_fail++;
            $display("FAIL wr_beats_tick_count got count=%02h want %02h", rd_data, e.data);
        end
        apb_write(8'h03, 8'hFE, wr_err);
        apb_write(8'h00, 8'h03, wr_err);
        apb_write(8'h04, 8'h01, wr_err);
        n_checks++;
        if (IRQ !== 1'b1) begin
            n_fail++;
            $display("FAIL set_beats_w1c_irq got irq=%0b want 1", IRQ);
        end
        exp_q.push_back('{8'h04, 8'h01, 1'b0});
        apb_read(exp_q[0].addr, rd_data, rd_err, rd_rdy);
        e = exp_q.pop_front();
        n_checks++;
        if (rd_data !== e.data) begin
            n_fail++;
            $display("FAIL set_beats_w1c_status got status=%02h want %02h", rd_data, e.data);
        end
        apb_write(8'h00, 8'h00, wr_err);
    endtask

`ifdef TMR_PRESCALER_EN
    task automatic test_prescaler();
        exp_t e;
        apb_write(8'h04, 8'h03, wr_err);
        apb_write(8'h05, 8'h03, wr_err);
        apb_write(8'h02, 8'h02, wr_err);
        apb_write(8'h03, 8'h00, wr_err);
        apb_write(8'h00, 8'h05, wr_err);
        for (int i = 1; i <= 8; i++) begin
            @(posedge PCLK); #1;
            n_checks++;
            if (IRQ !== (i == 8)) begin
                n_fail++;
                $display("FAIL presc_cmp cycle=%0d got irq=%0b want %0b", i, IRQ, (i == 8));
            end
        end
        exp_q.push_back('{8'h05, 8'h03, 1'b0});
        apb_read(exp_q[0].addr, rd_data, rd_err, rd_rdy);
        e = exp_q.pop_front();
        n_checks++;
        if (rd_data !== e.data || rd_err !== e.err) begin
            n_fail++;
            $display("FAIL presc_read got %02h/%0b want %02h/%0b", rd_data, rd_err, e.data, e.err);
        end
    endtask
`endif

    task automatic test_reset_midway();
        exp_t e;
        apb_write(8'h01, 8'h33, wr_err);
        apb_write(8'h02, 8'h44, wr_err);
        apb_write(8'h03, 8'hFE, wr_err);
        apb_write(8'h00, 8'h03, wr_err);
        repeat (10) @(posedge PCLK);
        #1;
        n_checks++;
        if (IRQ !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre_irq got irq=%0b want 1", IRQ);
        end
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h01; PWDATA = 8'h77;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        PRESET  = 1'b1;
        #1;
        n_checks++;
        if (IRQ !== 1'b0 || PREADY !== 1'b1 || PSLVERR !== 1'b0 || PRDATA !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_outputs got irq=%0b ready=%0b slverr=%0b prdata=%02h want 0 1 0 00",
                     IRQ, PREADY, PSLVERR, PRDATA);
        end
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PRESET = 1'b0;
        $display("apb wr addr=01 data=77 aborted by reset");
        exp_q.push_back('{8'h00, 8'h00, 1'b0});
        exp_q.push_back('{8'h01, 8'h00, 1'b0});
        exp_q.push_back('{8'h02, 8'hFF, 1'b0});
        exp_q.push_back('{8'h03, 8'h00, 1'b0});
        exp_q.push_back('{8'h04, 8'h00, 1'b0});
`ifdef TMR_PRESCALER_EN
        exp_q.push_back('{8'h05, 8'h00, 1'b0});
`endif
        while (exp_q.size() > 0) begin
            apb_read(exp_q[0].addr, rd_data, rd_err, rd_rdy);
            e = exp_q.pop_front();
            n_checks++;
            if (rd_data !== e.data || rd_err !== e.err) begin
                n_fail++;
                $display("FAIL midrst_read addr=%02h got %02h/%0b want %02h/%0b", e.addr, rd_data, rd_err, e.data, e.err);
            end
        end
        n_checks++;
        if (IRQ !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_post_irq got irq=%0b want 0", IRQ);
        end
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_compare();
        test_oneshot();
        test_error();
        test_back_to_back();
`ifdef TMR_PRESCALER_EN
        test_prescaler();
`endif
        test_reset_midway();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
